// File: rtl/mul_div_controller.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// with sign handling at operand latch and a final fixup cycle that negates and selects the result.
module mul_div_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  MDU_OP,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic [31:0] RESULT,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DIV_ITER = 2'd2,
    FIXUP    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        special_q, special_d;
  logic        hold_q, hold_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept_s, sgn1_s, sgn2_s, neg1_s, neg2_s;
  logic        is_rem_s, div_zero_s, ovf_s, special_s;
  logic [31:0] mag1_s, mag2_s, spec_val_s, div_sel_s, fix_val_s;
  logic [32:0] mul_sum_s, rem_sh_s, diff_s;
  logic [63:0] mul_step_s, div_step_s, prod_s;

  assign accept_s   = (state_q == IDLE) && START;
  assign sgn1_s     = (MDU_OP != 3'b011) && (MDU_OP != 3'b101) && (MDU_OP != 3'b111);
  assign sgn2_s     = (MDU_OP == 3'b000) || (MDU_OP == 3'b001) || (MDU_OP == 3'b100) || (MDU_OP == 3'b110);
  assign neg1_s     = sgn1_s && DATA1[31];
  assign neg2_s     = sgn2_s && DATA2[31];
  assign mag1_s     = neg1_s ? (32'd0 - DATA1) : DATA1;
  assign mag2_s     = neg2_s ? (32'd0 - DATA2) : DATA2;
  assign is_rem_s   = MDU_OP[1];
  assign div_zero_s = (DATA2 == 32'd0);
  assign ovf_s      = ((MDU_OP == 3'b100) || (MDU_OP == 3'b110)) &&
                      (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
  assign special_s  = MDU_OP[2] && (div_zero_s || ovf_s);
  assign spec_val_s = div_zero_s ? (is_rem_s ? DATA1 : 32'hFFFF_FFFF)
                                 : (is_rem_s ? 32'h0000_0000 : 32'h8000_0000);

  // Multiply keeps {partial product, remaining multiplier bits}; divide keeps {remainder, quotient}.
  assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_step_s = {mul_sum_s, acc_q[31:1]};
  assign rem_sh_s   = {acc_q[63:32], acc_q[31]};
  assign diff_s     = rem_sh_s - {1'b0, b_q};
  assign div_step_s = diff_s[32] ? {rem_sh_s[31:0], acc_q[30:0], 1'b0}
                                 : {diff_s[31:0],   acc_q[30:0], 1'b1};

  assign prod_s    = neg_q ? (64'd0 - acc_q) : acc_q;
  assign div_sel_s = op_q[1] ? acc_q[63:32] : acc_q[31:0];
  assign fix_val_s = special_q ? spec_val_q :
                     op_q[2]   ? (neg_q ? (32'd0 - div_sel_s) : div_sel_s) :
                     (op_q == 3'b000) ? prod_s[31:0] : prod_s[63:32];

  // State and all registered outputs/datapath
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      b_q        <= 32'd0;
      acc_q      <= 64'd0;
      cnt_q      <= 6'd0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      hold_q     <= 1'b0;
      spec_val_q <= 32'd0;
      result_q   <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      special_q  <= special_d;
      hold_q     <= hold_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; special divides linger one extra FIXUP cycle for a fixed k+2 latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (special_s)      state_d = FIXUP;
          else if (MDU_OP[2]) state_d = DIV_ITER;
          else                state_d = MUL_ITER;
        end else begin
          state_d = IDLE;
        end
      end
      MUL_ITER, DIV_ITER: begin
        if (cnt_q == 6'd32) state_d = FIXUP;
        else                state_d = state_q;
      end
      FIXUP: begin
        if (hold_q) state_d = FIXUP;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    special_d  = special_q;
    hold_d     = hold_q;
    spec_val_d = spec_val_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d       = MDU_OP;
          b_d        = mag2_s;
          acc_d      = {32'd0, mag1_s};
          cnt_d      = 6'd0;
          neg_d      = (MDU_OP[2] && is_rem_s) ? neg1_s : (neg1_s ^ neg2_s);
          special_d  = special_s;
          hold_d     = special_s;
          spec_val_d = spec_val_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      MUL_ITER: begin
        if (cnt_q != 6'd32) begin
          acc_d = mul_step_s;
          cnt_d = cnt_q + 6'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      DIV_ITER: begin
        if (cnt_q != 6'd32) begin
          acc_d = div_step_s;
          cnt_d = cnt_q + 6'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      FIXUP:   hold_d = 1'b0;
      default: hold_d = 1'b0;
    endcase
  end

  // Output logic: RESULT and DONE update on the FIXUP -> IDLE edge
  always_comb begin
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    if ((state_q == FIXUP) && (state_d == IDLE)) begin
      result_d = fix_val_s;
      done_d   = 1'b1;
    end else begin
      done_d   = 1'b0;
    end
  end

  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_mul_div_controller.sv
// Randomized and directed bench for mul_div_controller against an arithmetic reference model.
module tb_mul_div_controller;

  logic        CLK, RESET, START;
  logic [2:0]  MDU_OP;
  logic [31:0] DATA1, DATA2, RESULT;
  logic        BUSY, DONE;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_result = 32'd0;

  mul_div_controller dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MDU_OP(MDU_OP),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'd0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Runs one operation; 'now' starts it in the current (DONE) cycle, 'extra' fires a START at k+5.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit extra, input bit now);
    logic [31:0] exp, prev;
    int exp_lat, lat, busy_bad, hold_bad;
    bit got;
    exp     = ref_mdu(op, a, b);
    exp_lat = ref_latency(op, a, b);
    prev    = last_result;
    if (!now) begin
      @(negedge CLK);
      check("done_idle", {31'd0, DONE}, 32'd0);
    end
    MDU_OP = op; DATA1 = a; DATA2 = b; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    DATA1 = $urandom; DATA2 = $urandom; MDU_OP = 3'($urandom);
    lat = 0; got = 1'b0; busy_bad = 0; hold_bad = 0;
    while (!got && lat < 60) begin
      @(negedge CLK);
      if (DONE) begin
        got = 1'b1;
      end else begin
        if (!BUSY) busy_bad++;
        if (RESULT !== prev) hold_bad++;
        START = extra && (lat == 4);
        if (START) begin DATA1 = $urandom; DATA2 = $urandom; MDU_OP = 3'($urandom); end
        @(posedge CLK);
        #1 START = 1'b0;
        lat++;
      end
    end
    check($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
    check($sformatf("result op%0d %h %h", op, a, b), RESULT, exp);
    check("busy_in_done", {31'd0, BUSY}, 32'd0);
    check("busy_while_active", 32'(busy_bad), 32'd0);
    check("result_hold", 32'(hold_bad), 32'd0);
    last_result = exp;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    RESET = 1'b1; START = 1'b0; MDU_OP = 3'd0; DATA1 = 32'd0; DATA2 = 32'd0;
    #12;
    check("reset_result", RESULT, 32'd0);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK) RESET = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    do_op(3'd5, 32'd100, 32'd7, 1'b1, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, 1'b0, 1'b0);
    do_op(3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom), pick_operand(), pick_operand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Abort a divide mid-flight with an asynchronous reset
    @(negedge CLK);
    MDU_OP = 3'd4; DATA1 = 32'h7654_3210; DATA2 = 32'd3; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_result", RESULT, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK) RESET = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    check("no_done_after_abort", 32'(dn), 32'd0);
    last_result = 32'd0;
    do_op(3'd0, 32'd3, 32'd4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_controller.md
MUL_DIV_CONTROLLER -- requirements
Module: mul_div_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named CLK and RESET.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous active-high reset.
REQ-004 START  input  1  single-cycle request pulse; sampled only when BUSY=0.
REQ-005 MDU_OP  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 DATA1  input  32  rs1 operand (multiplicand/dividend).
REQ-007 DATA2  input  32  rs2 operand (multiplier/divisor).
REQ-008 RESULT  output  32  registered result; holds its value until the next DONE.
REQ-009 BUSY  output  1  high while an operation is in flight; the pipeline stalls EX on BUSY.
REQ-010 DONE  output  1  single-cycle pulse; RESULT is valid in the same cycle.

Function
REQ-011 States SHALL be: IDLE, MUL_ITER, DIV_ITER, FIXUP.
REQ-012 IDLE with START=1 at edge k SHALL latch MDU_OP, DATA1 and DATA2; operand changes after edge k SHALL be ignored.
REQ-013 Transition out of IDLE on START: MDU_OP[2]=0 goes to MUL_ITER, MDU_OP[2]=1 goes to DIV_ITER, except the special divide cases in REQ-018/019, which go to FIXUP.
REQ-014 Signed operands (MUL/MULH/DIV/REM: both; MULHSU: DATA1 only) SHALL be converted to magnitudes at latch time, and the result sign SHALL be recorded.
REQ-015 MUL_ITER SHALL perform 32 unsigned shift-add iterations, one per cycle, into a 64-bit accumulator, using a 6-bit counter; then go to FIXUP.
REQ-016 DIV_ITER SHALL perform 32 restoring-division iterations, one per cycle, producing a 32-bit quotient and a 32-bit remainder; then go to FIXUP.
REQ-017 FIXUP (one cycle) SHALL apply two's-complement negation where required and select the output:
- MUL: low 32 bits; MULH/MULHSU/MULHU: high 32 bits.
- Quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
- FIXUP then returns to IDLE, loading RESULT and pulsing DONE in the first IDLE cycle.
REQ-018 Divisor=0 SHALL skip iteration: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1 unchanged.
REQ-019 DIV with 0x80000000 / 0xFFFFFFFF SHALL skip iteration: DIV gives 0x80000000; REM gives 0x00000000.
REQ-020 Latency: normal operations assert DONE in the cycle after edge k+34; special cases assert DONE in the cycle after edge k+2.
REQ-021 BUSY SHALL be 1 in MUL_ITER, DIV_ITER and FIXUP, and 0 in IDLE, including the DONE cycle.
REQ-022 START while BUSY=1 SHALL be ignored with no side effects.
REQ-023 START in the DONE cycle SHALL be accepted (back-to-back operation); DONE and the RESULT value of the previous operation SHALL be unaffected.
REQ-024 All arithmetic SHALL be modulo 2^32 on outputs; no overflow flags.

Reset
REQ-025 On RESET=1, asynchronously and regardless of state: state=IDLE, RESULT=0, BUSY=0, DONE=0, counter=0, accumulators cleared.
REQ-026 A reset during an operation SHALL abort it; no DONE pulse for the aborted operation; the first START after release SHALL behave normally.

Verification
REQ-027 MUL, DATA1=7, DATA2=0xFFFFFFFD, START at edge k -> BUSY=1 for k+1..k+34; DONE=1 after edge k+34; RESULT=0xFFFFFFEB.
REQ-028 MULH 0x80000000 x 0x80000000 -> RESULT=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> RESULT=0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> RESULT=0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9 / 2 -> RESULT=0xFFFFFFFD; REM same operands -> RESULT=0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 DIVU 0x1234 / 0 -> DONE after edge k+2, RESULT=0xFFFFFFFF; REM 0x80000000 / 0xFFFFFFFF -> DONE after edge k+2, RESULT=0.
REQ-031 Second START at k+5 with different operands -> ignored; RESULT reflects only the first operation; a START in the DONE cycle -> new BUSY from the next edge.
REQ-032 RESET pulsed at k+10 mid-DIV -> BUSY=0 and RESULT=0 immediately; no DONE for the next 40 cycles; a subsequent MUL 3x4 -> RESULT=12.
